// File: rtl/rf_sb_pkg.sv
// Shared widths and counter type for the register-file scoreboard.
package rf_sb_pkg;

   localparam int AR_BITS  = 5;
   localparam int CNT_BITS = 2;
   localparam int NUM_REGS = 1 << AR_BITS;

   typedef logic [CNT_BITS-1:0] cnt_t;

   localparam cnt_t CNT_MAX = cnt_t'((1 << CNT_BITS) - 1);

endpackage

// File: rtl/rf_sb_cnt.sv
// One scoreboard slot: saturating up/down pending-write counter with an
// underflow/overflow flag and a registered non-zero indicator.
module rf_sb_cnt #(
   parameter int CNT_BITS = rf_sb_pkg::CNT_BITS
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                inc_i,
   input  logic                dec_wb_i,
   input  logic                dec_kill_i,
   output logic [CNT_BITS-1:0] cnt_o,
   output logic                busy_o,
   output logic                err_o
);

   localparam int SW = CNT_BITS + 2;

   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [SW-1:0]       sum;
   logic                under, over;
   logic                busy_q;

   // Two spare bits let the net delta go to -2 or MAX+1 without wrapping.
   always_comb begin
      sum   = SW'(cnt_q) + SW'(inc_i) - SW'(dec_wb_i) - SW'(dec_kill_i);
      under = sum[SW-1];
      over  = !under && sum[CNT_BITS];
      cnt_d = cnt_q;
      if (under) begin
         cnt_d = '0;
      end else if (!over) begin
         cnt_d = sum[CNT_BITS-1:0];
      end
   end

   // NOTE: state updates use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= (cnt_d != '0);
      end
   end

   assign cnt_o  = cnt_q;
   assign busy_o = busy_q;
   assign err_o  = under || over;

endmodule

// File: rtl/rf_sb_ctrl.sv
// Scoreboard and issue controller: RAW/saturation stall for ID, EX kill
// shadow register, and sticky protocol error.
module rf_sb_ctrl #(
   parameter int AR_BITS   = rf_sb_pkg::AR_BITS,
   parameter int CNT_BITS  = rf_sb_pkg::CNT_BITS,
   parameter bit WB_BYPASS = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    id_valid_i,
   input  logic [AR_BITS-1:0]      id_rs1_i,
   input  logic [AR_BITS-1:0]      id_rs2_i,
   input  logic                    id_rs1_use_i,
   input  logic                    id_rs2_use_i,
   input  logic [AR_BITS-1:0]      id_rd_i,
   input  logic                    id_rd_we_i,
   input  logic                    ex_stall_i,
   input  logic                    ex_kill_i,
   input  logic                    wb_we_i,
   input  logic [AR_BITS-1:0]      wb_dst_i,
   output logic                    stall_o,
   output logic                    issue_o,
   output logic [(1<<AR_BITS)-1:0] busy_o,
   output logic                    idle_o,
   output logic                    err_o
);

   localparam int NREGS = 1 << AR_BITS;

   logic [CNT_BITS-1:0] cnt [NREGS-1:1];
   logic [NREGS-1:0]    hz, sat;
   logic [NREGS-1:1]    inc, dec_wb, dec_kill, cnt_err, busy_hi;
   logic [AR_BITS-1:0]  ex_rd_q;
   logic                ex_rd_v_q;
   logic                err_q;

   // x0 keeps hz/sat at 0 and has no counter, so index 0 never stalls or counts.
   always_comb begin
      hz       = '0;
      sat      = '0;
      inc      = '0;
      dec_wb   = '0;
      dec_kill = '0;
      for (int r = 1; r < NREGS; r++) begin
         hz[r]       = (cnt[r] != '0) &&
                       !(WB_BYPASS && wb_we_i && (wb_dst_i == AR_BITS'(r)) &&
                         (cnt[r] == CNT_BITS'(1)));
         sat[r]      = &cnt[r];
         inc[r]      = issue_o && id_rd_we_i && (id_rd_i == AR_BITS'(r));
         dec_wb[r]   = wb_we_i && (wb_dst_i == AR_BITS'(r));
         dec_kill[r] = ex_kill_i && ex_rd_v_q && (ex_rd_q == AR_BITS'(r));
      end
   end

   assign stall_o = id_valid_i && ((id_rs1_use_i && hz[id_rs1_i]) ||
                                   (id_rs2_use_i && hz[id_rs2_i]) ||
                                   (id_rd_we_i   && sat[id_rd_i]));
   // A kill flushes ID as well, so nothing may issue alongside it.
   assign issue_o = id_valid_i && !stall_o && !ex_stall_i && !ex_kill_i;

   for (genvar r = 1; r < NREGS; r++) begin : g_cnt
      rf_sb_cnt #(.CNT_BITS(CNT_BITS)) u_cnt (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .inc_i      (inc[r]),
         .dec_wb_i   (dec_wb[r]),
         .dec_kill_i (dec_kill[r]),
         .cnt_o      (cnt[r]),
         .busy_o     (busy_hi[r]),
         .err_o      (cnt_err[r])
      );
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_rd_q   <= '0;
         ex_rd_v_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (!ex_stall_i) begin
            ex_rd_q   <= id_rd_i;
            ex_rd_v_q <= issue_o && id_rd_we_i && (id_rd_i != '0);
         end
         if (|cnt_err) begin
            err_q <= 1'b1;
         end
      end
   end

   assign busy_o = {busy_hi, 1'b0};
   assign idle_o = ~|busy_o;
   assign err_o  = err_q;

endmodule

// File: tb/tb_rf_sb_ctrl.sv
// Directed bench for rf_sb_ctrl: RAW stall with/without WB bypass, saturation,
// EX kill, x0 handling, sticky error and asynchronous reset.
module tb_rf_sb_ctrl;
   import rf_sb_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        id_valid_i = 1'b0;
   logic [4:0]  id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0, wb_dst_i = '0;
   logic        id_rs1_use_i = 1'b0, id_rs2_use_i = 1'b0, id_rd_we_i = 1'b0;
   logic        ex_stall_i = 1'b0, ex_kill_i = 1'b0, wb_we_i = 1'b0;
   logic        stall_o, issue_o, idle_o, err_o;
   logic [31:0] busy_o;
   logic        nb_stall, nb_issue, nb_idle, nb_err;
   logic [31:0] nb_busy;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk_i = ~clk_i;

   rf_sb_ctrl #(.AR_BITS(5), .CNT_BITS(2), .WB_BYPASS(1'b1)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_rs1_use_i(id_rs1_use_i), .id_rs2_use_i(id_rs2_use_i),
      .id_rd_i(id_rd_i), .id_rd_we_i(id_rd_we_i),
      .ex_stall_i(ex_stall_i), .ex_kill_i(ex_kill_i),
      .wb_we_i(wb_we_i), .wb_dst_i(wb_dst_i),
      .stall_o(stall_o), .issue_o(issue_o), .busy_o(busy_o),
      .idle_o(idle_o), .err_o(err_o)
   );

   rf_sb_ctrl #(.AR_BITS(5), .CNT_BITS(2), .WB_BYPASS(1'b0)) dut_nb (
      .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_rs1_use_i(id_rs1_use_i), .id_rs2_use_i(id_rs2_use_i),
      .id_rd_i(id_rd_i), .id_rd_we_i(id_rd_we_i),
      .ex_stall_i(ex_stall_i), .ex_kill_i(ex_kill_i),
      .wb_we_i(wb_we_i), .wb_dst_i(wb_dst_i),
      .stall_o(nb_stall), .issue_o(nb_issue), .busy_o(nb_busy),
      .idle_o(nb_idle), .err_o(nb_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic id_set(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic we);
      id_valid_i   = v;
      id_rs1_i     = rs1;
      id_rs1_use_i = u1;
      id_rs2_i     = rs2;
      id_rs2_use_i = u2;
      id_rd_i      = rd;
      id_rd_we_i   = we;
   endtask

   task automatic wb_set(input logic we, input logic [4:0] dst);
      wb_we_i  = we;
      wb_dst_i = dst;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_busy", busy_o, 0);
      check("rst_idle", idle_o, 1);
      check("rst_err", err_o, 0);
      check("rst_stall", stall_o, 0);
      check("rst_issue", issue_o, 0);
      rst_i = 1'b0;

      // addi x5 then add x6,x5,x5; x5 commits in cycle 3
      id_set(1, 0, 0, 0, 0, 5, 1);
      #1 check("addi_issue", issue_o, 1);
      tick();
      id_set(1, 5, 1, 5, 1, 6, 1);
      #1 check("raw_c1_stall", stall_o, 1);
      check("raw_c1_issue", issue_o, 0);
      check("raw_c1_busy", busy_o, 32'h0000_0020);
      tick();
      #1 check("raw_c2_stall", stall_o, 1);
      tick();
      wb_set(1, 5);
      #1 check("raw_c3_stall", stall_o, 0);
      check("raw_c3_issue", issue_o, 1);
      check("nobyp_c3_stall", nb_stall, 1);
      tick();
      id_set(0, 0, 0, 0, 0, 0, 0);
      wb_set(0, 0);
      #1 check("raw_busy_after", busy_o, 32'h0000_0040);
      wb_set(1, 6);
      tick();
      wb_set(0, 0);
      #1 check("raw_idle", idle_o, 1);
      check("raw_err", err_o, 0);

      // Saturate x7
      for (int i = 0; i < int'(CNT_MAX); i++) begin
         id_set(1, 0, 0, 0, 0, 7, 1);
         #1 check("sat_fill_issue", issue_o, 1);
         tick();
      end
      #1 check("sat_stall", stall_o, 1);
      check("sat_no_issue", issue_o, 0);
      check("sat_busy", busy_o, 32'h0000_0080);
      wb_set(1, 7);
      #1 check("sat_wb_same_cycle_stall", stall_o, 1);
      tick();
      wb_set(0, 0);
      #1 check("sat_release_stall", stall_o, 0);
      check("sat_release_issue", issue_o, 1);
      tick();
      id_set(0, 0, 0, 0, 0, 0, 0);
      wb_set(1, 7);
      repeat (3) tick();
      wb_set(0, 0);
      #1 check("sat_drain_idle", idle_o, 1);
      check("sat_drain_err", err_o, 0);

      // lw x8 killed in EX
      id_set(1, 0, 0, 0, 0, 8, 1);
      #1 check("kill_lw_issue", issue_o, 1);
      tick();
      ex_kill_i = 1'b1;
      id_set(1, 0, 0, 0, 0, 9, 1);
      #1 check("kill_suppress_issue", issue_o, 0);
      tick();
      ex_kill_i = 1'b0;
      id_set(0, 0, 0, 0, 0, 0, 0);
      #1 check("kill_busy8", busy_o[8], 0);
      check("kill_busy", busy_o, 0);
      check("kill_idle", idle_o, 1);
      check("kill_err", err_o, 0);

      // x0 as source and destination, then a kill of that EX slot
      id_set(1, 0, 1, 0, 1, 0, 1);
      #1 check("x0_stall", stall_o, 0);
      check("x0_issue", issue_o, 1);
      tick();
      id_set(0, 0, 0, 0, 0, 0, 0);
      ex_kill_i = 1'b1;
      tick();
      ex_kill_i = 1'b0;
      #1 check("x0_busy0", busy_o[0], 0);
      check("x0_idle", idle_o, 1);
      check("x0_kill_err", err_o, 0);

      // WB to x9 with nothing pending
      wb_set(1, 9);
      tick();
      wb_set(0, 0);
      #1 check("under_err", err_o, 1);
      check("under_busy", busy_o, 0);
      tick();
      #1 check("under_err_sticky", err_o, 1);

      // x10, x11 pending, then asynchronous reset mid-cycle
      id_set(1, 0, 0, 0, 0, 10, 1);
      tick();
      id_set(1, 0, 0, 0, 0, 11, 1);
      tick();
      id_set(0, 0, 0, 0, 0, 0, 0);
      #1 check("pre_rst_busy", busy_o, 32'h0000_0C00);
      check("pre_rst_idle", idle_o, 0);
      #1 rst_i = 1'b1;
      #1 check("async_rst_busy", busy_o, 0);
      check("async_rst_idle", idle_o, 1);
      check("async_rst_err", err_o, 0);
      #1 rst_i = 1'b0;
      id_set(1, 10, 1, 11, 1, 12, 1);
      #1 check("post_rst_stall", stall_o, 0);
      check("post_rst_issue", issue_o, 1);
      tick();
      id_set(0, 0, 0, 0, 0, 0, 0);
      #1 check("post_rst_busy", busy_o, 32'h0000_1000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/rf_sb_ctrl.md
# rf_sb_ctrl

Register-file scoreboard and issue controller for the RV12 integer pipeline. It tracks how many in-flight instructions (EX, MEM, WB) will write each architectural register. It stalls ID on a read-after-write hazard or on counter saturation, and releases entries when writeback commits or an EX instruction is killed. It sits beside `int_rf`, taking ID decode fields, the EX kill, and the WB write port (`wb_we`/`wb_dst`).

## Interface
Parameters:
- `AR_BITS`, 5: architectural register index width.
- `CNT_BITS`, 2: per-register pending counter width; maximum outstanding writes per register is 2^CNT_BITS−1.
- `WB_BYPASS`, 1: when 1, a same-cycle WB commit to a register clears that register's hazard in the current cycle.

Ports (clock and reset first):
- `clk_i`  in  1  clock; all state is updated on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `id_valid_i`  in  1  ID holds a non-bubble instruction.
- `id_rs1_i` / `id_rs2_i`  in  AR_BITS  source register indices.
- `id_rs1_use_i` / `id_rs2_use_i`  in  1  the instruction reads that source.
- `id_rd_i`  in  AR_BITS  destination register index.
- `id_rd_we_i`  in  1  the instruction writes `rd`.
- `ex_stall_i`  in  1  downstream stall; no issue can happen this cycle.
- `ex_kill_i`  in  1  the instruction now in EX (the one issued last cycle) is killed (exception or branch flush).
- `wb_we_i`  in  1  WB register-file write.
- `wb_dst_i`  in  AR_BITS  WB destination index.
- `stall_o`  out  1  hazard stall to ID; combinational.
- `issue_o`  out  1  the ID instruction advances to EX this cycle; combinational.
- `busy_o`  out  2^AR_BITS  one bit per register, set when its counter is non-zero; registered.
- `idle_o`  out  1  no pending writes anywhere.
- `err_o`  out  1  sticky protocol error.

## Operation
- Per-register counter `cnt[r]`, r = 1..31. Register x0 is never tracked: its counter is hardwired 0, and indices equal to 0 are ignored on every path.
- `hz(r)` = `cnt[r] != 0`, excluding the case `WB_BYPASS && wb_we_i && wb_dst_i == r && cnt[r] == 1`.
- `stall_o` = `id_valid_i` && (
  - (`rs1_use` && `hz(rs1)`), or
  - (`rs2_use` && `hz(rs2)`), or
  - (`rd_we` && `cnt[rd]` saturated)).
- `issue_o` = `id_valid_i` && !`stall_o` && !`ex_stall_i`.
- Shadow register `ex_rd`/`ex_rd_v` captures `id_rd_i` and (`issue_o` && `id_rd_we_i` && rd≠0) whenever EX advances (!`ex_stall_i`). When `ex_stall_i` is high it holds.
- Counter next value: `cnt[r]` + inc − dec_wb − dec_kill, each term 0 or 1.
  - inc = issue to r.
  - dec_wb = `wb_we_i` to r.
  - dec_kill = `ex_kill_i` && `ex_rd_v` && `ex_rd` == r.
  - All three may hit the same r in one cycle; the net delta is applied.
- When `ex_kill_i` is asserted, `issue_o` is suppressed that cycle, because ID is flushed too.
- Error conditions, each setting `err_o`:
  - A decrement would make a counter negative. The counter holds at 0.
  - An increment would exceed saturation. This is unreachable if the stall is honoured; the counter holds.
- `idle_o` = all `busy_o` bits are 0.

## Timing
- Reset: all counters 0, `ex_rd_v` 0, `busy_o` 0, `idle_o` 1, `err_o` 0. `stall_o`/`issue_o` follow their inputs (0 when `id_valid_i` is 0).
- `stall_o` and `issue_o` have zero latency from the ID inputs and `wb_*`.
- `busy_o` reflects an issue or commit one cycle after it.
- A 3-deep EX→MEM→WB dependency with `WB_BYPASS=1` gives 2 stall cycles; with `WB_BYPASS=0` it gives 3.
- `rst_i` asserted mid-operation clears everything immediately, regardless of in-flight state.
- `err_o` clears only on reset.

## Structure
- Package `rf_sb_pkg`: `AR_BITS`, `CNT_BITS`, `cnt_t` typedef, and the `CNT_MAX` constant.
- Sub-module `rf_sb_cnt`: a single saturating up/down counter with an underflow/overflow flag, instantiated for r = 1..31 in a generate loop.
- The top level holds the hazard logic, the EX shadow register, and the error OR-reduction.

## Test plan
- After reset, issue `addi x5` and then `add x6,x5,x5` back-to-back, with WB committing x5 at cycle 3. Require `stall_o`=1 for cycles 1–2 and `issue_o`=1 in cycle 3 (`WB_BYPASS`=1).
- Issue `x7` three times with no WB. The fourth write to `x7` stalls (`cnt`=3). One WB to `x7` then releases it in the same cycle the counter drops.
- Issue `lw x8` and assert `ex_kill_i` the next cycle. Require `busy_o[8]`=0 one cycle later, `idle_o`=1, and `err_o`=0.
- Issue `x0` as destination and as source. Require no stall, and `busy_o[0]` stays 0.
- Pulse `wb_we_i` to `x9` while `cnt[9]`=0. Require `err_o`=1 (sticky) and the counter stays 0.
- With `x10` and `x11` pending, assert `rst_i` mid-stream. Require `busy_o`=0 and `idle_o`=1 asynchronously, and an immediate issue after release.
